// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_capture
//  Description : HUB75 receive-side panel model. Oversamples the driver's
//                shift clock, latch and data lanes, rebuilds each latched row
//                pair and writes it into an external frame memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_capture #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           A,
    input  logic                           B,
    input  logic                           C,
    input  logic                           D,
    input  logic                           R0,
    input  logic                           G0,
    input  logic                           B0,
    input  logic                           R1,
    input  logic                           G1,
    input  logic                           B1,
    input  logic                           clk_shft,
    input  logic                           LAT,
    input  logic                           OE,
    output logic                           wr_en,
    output logic [ROW_BITS+$clog2(COLS):0] wr_addr,
    output logic [2:0]                     wr_data,
    output logic                           frame_done,
    output logic                           oe_active,
    output logic                           len_err,
    output logic                           overrun
);

    localparam int                  CW       = $clog2(COLS);
    localparam int                  NIN      = 13;
    localparam logic [CW-1:0]       COL_LAST = CW'(COLS - 1);
    localparam logic [CW:0]         CNT_FULL = (CW+1)'(COLS);
    localparam logic [CW:0]         CNT_MAX  = (CW+1)'(2 * COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DUMP_UP = 2'd1,
        S_DUMP_LO = 2'd2
    } state_t;

    // Input bundle layout: [3:0] row {D,C,B,A}, [9:4] pixel {R0,G0,B0,R1,G1,B1},
    // [10] clk_shft, [11] LAT, [12] OE
    logic [NIN-1:0]          in_raw;
    logic [NIN-1:0]          sync1_q;
    logic [NIN-1:0]          sync2_q;
    logic [1:0]              sync3_q;

    logic                    shft_rise;
    logic                    lat_rise;
    logic [ROW_BITS-1:0]     row_in;
    logic [5:0]              pix_in;

    logic [COLS-1:0][5:0]    shreg_q;
    logic [COLS-1:0][5:0]    shreg_d;
    logic [COLS-1:0][5:0]    rowbuf_q;
    logic [CW:0]             cnt_q;
    logic [CW:0]             cnt_inc;
    logic [CW:0]             cnt_now;

    state_t                  state_q;
    logic [CW-1:0]           col_q;
    logic [ROW_BITS-1:0]     row_q;

    logic                    wr_en_q;
    logic [ROW_BITS+CW:0]    wr_addr_q;
    logic [2:0]              wr_data_q;
    logic                    frame_done_q;
    logic                    oe_active_q;
    logic                    len_err_q;
    logic                    overrun_q;

    assign in_raw = {OE, LAT, clk_shft, R0, G0, B0, R1, G1, B1, D, C, B, A};

    // Two-flop synchronizer for every input, plus a third delayed copy of the
    // two strobes so their edges line up with the stage-2 data and address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q[11:10];
        end
    end

    assign row_in    = sync2_q[ROW_BITS-1:0];
    assign pix_in    = sync2_q[9:4];
    assign shft_rise = sync2_q[10] & ~sync3_q[0];
    assign lat_rise  = sync2_q[11] & ~sync3_q[1];

    // Newest pixel enters column 0; the count saturates instead of wrapping
    always_comb begin
        shreg_d = shreg_q;
        if (shft_rise) begin
            shreg_d = {shreg_q[COLS-2:0], pix_in};
        end
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_now = shft_rise ? cnt_inc : cnt_q;
    end

    // Shift register runs freely, independent of the dump in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Latch acceptance, row dump sequencing and registered write-port outputs.
    // The accepting cycle already issues the column-0 write so the burst starts
    // the cycle after the latch edge and runs 2*COLS cycles back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            rowbuf_q     <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
            oe_active_q  <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            oe_active_q  <= ~sync2_q[12];
            if (shft_rise) begin
                cnt_q <= cnt_inc;
            end
            case (state_q)
                S_IDLE: begin
                    if (lat_rise) begin
                        rowbuf_q  <= shreg_d;
                        row_q     <= row_in;
                        cnt_q     <= '0;
                        if (cnt_now != CNT_FULL) begin
                            len_err_q <= 1'b1;
                        end
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {1'b0, row_in, {CW{1'b0}}};
                        wr_data_q <= shreg_d[0][5:3];
                        col_q     <= CW'(1);
                        state_q   <= S_DUMP_UP;
                    end
                end
                S_DUMP_UP: begin
                    if (lat_rise) begin
                        overrun_q <= 1'b1;
                    end
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {1'b0, row_q, col_q};
                    wr_data_q <= rowbuf_q[col_q][5:3];
                    if (col_q == COL_LAST) begin
                        col_q   <= '0;
                        state_q <= S_DUMP_LO;
                    end else begin
                        col_q   <= col_q + 1'b1;
                    end
                end
                S_DUMP_LO: begin
                    if (lat_rise) begin
                        overrun_q <= 1'b1;
                    end
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {1'b1, row_q, col_q};
                    wr_data_q <= rowbuf_q[col_q][2:0];
                    if (col_q == COL_LAST) begin
                        col_q        <= '0;
                        frame_done_q <= (row_q == ROW_LAST);
                        state_q      <= S_IDLE;
                    end else begin
                        col_q        <= col_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign oe_active  = oe_active_q;
    assign len_err    = len_err_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_capture
//  Description : Directed, table-driven self-checking bench for hub75_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_capture;

    logic        clk;
    logic        rst;
    logic        A, B, C, D;
    logic        R0, G0, B0, R1, G1, B1;
    logic        clk_shft, LAT, OE;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [2:0]  wr_data;
    logic        frame_done, oe_active, len_err, overrun;

    int tests = 0;
    int fails = 0;

    // Write-port monitor state
    logic [3:0]  mem [0:2047];
    int          wr_cnt = 0;
    int          bursts = 0;
    int          run = 0;
    int          last_run = 0;
    int          fd_cnt = 0;
    logic [10:0] fd_addr = '0;
    logic        fd_with_wr = 1'b0;
    logic        prev_en = 1'b0;

    typedef struct {
        logic [3:0] row;
        logic [2:0] x;
        logic [2:0] lo;
        int         n;
        logic       exp_len;
        int         exp_fd;
    } vec_t;

    vec_t vt [5];

    hub75_capture #(.COLS(64), .ROW_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .clk_shft(clk_shft), .LAT(LAT), .OE(OE),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .oe_active(oe_active),
        .len_err(len_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write and burst shape, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = {1'b0, wr_data};
            wr_cnt++;
            if (!prev_en) bursts++;
            run++;
        end else if (prev_en) begin
            last_run = run;
            run = 0;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_addr    = wr_addr;
            fd_with_wr = wr_en;
        end
        prev_en = wr_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic shift_pix(input logic [2:0] up, input logic [2:0] lo);
        {R0, G0, B0} = up;
        {R1, G1, B1} = lo;
        clk_shft = 1'b0;
        tick(2);
        clk_shft = 1'b1;
        tick(2);
        clk_shft = 1'b0;
    endtask

    // Column c carries upper = c[2:0]^x, lower = lo; first shifted is column n-1
    task automatic send_row(input logic [3:0] row, input logic [2:0] x,
                            input logic [2:0] lo, input int n);
        logic [2:0] cu;
        {D, C, B, A} = row;
        for (int k = 0; k < n; k++) begin
            cu = 3'(n - 1 - k);
            shift_pix(cu ^ x, lo);
        end
        tick(2);
        LAT = 1'b1;
        tick(2);
        LAT = 1'b0;
    endtask

    function automatic int row_bad(input logic [3:0] row, input logic [2:0] x,
                                   input logic [2:0] lo, input int n);
        int          bad = 0;
        logic [10:0] a;
        logic [2:0]  cu;
        for (int c = 0; c < n; c++) begin
            cu = 3'(c);
            a  = {1'b0, row, 6'(c)};
            if (mem[a] !== {1'b0, cu ^ x}) bad++;
            a  = {1'b1, row, 6'(c)};
            if (mem[a] !== {1'b0, lo}) bad++;
        end
        return bad;
    endfunction

    initial begin
        int          w0, fd0, b0, bad;
        logic [3:0]  r;
        logic [10:0] a;

        vt[0] = '{row: 4'd5,  x: 3'd0, lo: 3'b101, n: 64, exp_len: 1'b0, exp_fd: 0};
        vt[1] = '{row: 4'd10, x: 3'd7, lo: 3'b010, n: 64, exp_len: 1'b0, exp_fd: 0};
        vt[2] = '{row: 4'd15, x: 3'd5, lo: 3'b111, n: 64, exp_len: 1'b0, exp_fd: 1};
        vt[3] = '{row: 4'd3,  x: 3'd2, lo: 3'b001, n: 63, exp_len: 1'b1, exp_fd: 0};
        vt[4] = '{row: 4'd7,  x: 3'd6, lo: 3'b100, n: 64, exp_len: 1'b1, exp_fd: 0};

        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        {A, B, C, D, R0, G0, B0, R1, G1, B1, clk_shft, LAT, OE} = 13'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            {A, B, C, D, R0, G0, B0, R1, G1, B1, clk_shft, LAT, OE} = 13'($urandom);
        end
        @(negedge clk);
        chk("reset_outs", int'({wr_en, wr_addr, wr_data, frame_done, oe_active, len_err, overrun}), 0);
        @(posedge clk);
        #1;
        clk_shft = 1'b0;
        LAT      = 1'b0;
        rst      = 1'b0;
        w0 = wr_cnt;
        tick(10);
        chk("no_wr_after_rst", wr_cnt - w0, 0);

        OE = 1'b0;
        tick(4);
        chk("oe_active_low_oe", int'(oe_active), 1);
        OE = 1'b1;
        tick(4);
        chk("oe_active_high_oe", int'(oe_active), 0);
        OE = 1'b0;

        // ---------------- full frame ----------------
        w0  = wr_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) begin
            r = 4'(i);
            send_row(r, r[2:0], ~r[2:0], 64);
            tick(140);
        end
        chk("frame_writes", wr_cnt - w0, 2048);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("frame_done_addr", int'(fd_addr), 2047);
        chk("frame_done_with_wr", int'(fd_with_wr), 1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            r = 4'(i);
            bad += row_bad(r, r[2:0], ~r[2:0], 64);
        end
        chk("frame_data_bad", bad, 0);
        chk("frame_len_err", int'(len_err), 0);

        // ---------------- table-driven rows ----------------
        for (int v = 0; v < 5; v++) begin
            w0  = wr_cnt;
            fd0 = fd_cnt;
            send_row(vt[v].row, vt[v].x, vt[v].lo, vt[v].n);
            tick(140);
            chk($sformatf("vec%0d_writes", v), wr_cnt - w0, 128);
            chk($sformatf("vec%0d_data_bad", v), row_bad(vt[v].row, vt[v].x, vt[v].lo, vt[v].n), 0);
            chk($sformatf("vec%0d_len_err", v), int'(len_err), int'(vt[v].exp_len));
            chk($sformatf("vec%0d_frame_done", v), fd_cnt - fd0, vt[v].exp_fd);
            chk($sformatf("vec%0d_overrun", v), int'(overrun), 0);
        end

        // ---------------- overrun: second latch 20 cycles later ----------------
        w0 = wr_cnt;
        b0 = bursts;
        send_row(4'd2, 3'd4, 3'b011, 64);
        {D, C, B, A} = 4'd9;
        tick(18);
        LAT = 1'b1;
        tick(2);
        LAT = 1'b0;
        tick(140);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_writes", wr_cnt - w0, 128);
        chk("ovr_bursts", bursts - b0, 1);
        chk("ovr_run_len", last_run, 128);
        chk("ovr_data_bad", row_bad(4'd2, 3'd4, 3'b011, 64), 0);

        // ---------------- clk_shft and LAT rise together ----------------
        w0 = wr_cnt;
        {D, C, B, A} = 4'd12;
        for (int k = 0; k < 63; k++) shift_pix(3'b001, 3'b000);
        {R0, G0, B0} = 3'b110;
        {R1, G1, B1} = 3'b100;
        clk_shft = 1'b0;
        tick(2);
        clk_shft = 1'b1;
        LAT      = 1'b1;
        tick(2);
        clk_shft = 1'b0;
        LAT      = 1'b0;
        tick(140);
        chk("sim_writes", wr_cnt - w0, 128);
        a = {1'b0, 4'd12, 6'd0};
        chk("sim_col0_upper", int'(mem[a]), 4'b0110);
        a = {1'b1, 4'd12, 6'd0};
        chk("sim_col0_lower", int'(mem[a]), 4'b0100);
        a = {1'b0, 4'd12, 6'd1};
        chk("sim_col1_upper", int'(mem[a]), 4'b0001);
        a = {1'b0, 4'd12, 6'd63};
        chk("sim_col63_upper", int'(mem[a]), 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
